// File: rtl/seq_ctrl_pkg.sv
// Shared definitions for the one-hot control sequencer: idle index and
// helpers to encode and validate one-hot state vectors.
package seq_ctrl_pkg;

  localparam int IDLE_IDX   = 0;
  // Helpers take a fixed-width vector; callers zero-extend their state.
  localparam int MAX_STATES = 32;

  // Binary index of the set bit; with several bits set the highest wins.
  function automatic int onehot_enc(input logic [MAX_STATES-1:0] vec);
    int idx;
    idx = 0;
    for (int i = 0; i < MAX_STATES; i++) begin
      if (vec[i]) idx = i;
    end
    return idx;
  endfunction

  // True when exactly one bit is set.
  function automatic logic is_onehot(input logic [MAX_STATES-1:0] vec);
    int cnt;
    cnt = 0;
    for (int i = 0; i < MAX_STATES; i++) begin
      if (vec[i]) cnt++;
    end
    return (cnt == 1);
  endfunction

endpackage

// File: rtl/seq_onehot_chk.sv
// Legality check of the one-hot state vector (popcount == 1).
module seq_onehot_chk
  import seq_ctrl_pkg::*;
#(
  parameter int N_STATES = 6
) (
  input  logic [N_STATES-1:0] state,
  output logic                legal
);

  // Zero-extension cannot add set bits, so the check is exact.
  assign legal = is_onehot(MAX_STATES'(state));

endmodule

// File: rtl/seq_control_gen.sv
// Parametrised one-hot control sequencer. Each STATE bit is a datapath step
// strobe; the sequence is 0 -> 1 -> ... -> N_STATES-1 with one CLR branch
// and a configurable loop-back point, plus single-shot mode, pass counter,
// DONE pulse and recovery from illegal (non one-hot) state.
//
// state index   | meaning
// 0             | idle / reset; waits for START in single-shot mode
// 1..N-2        | step strobes; BR_FROM samples CLR to jump to BR_TO
// N_STATES-1    | last step; exit pulses DONE and bumps LOOP_CNT
module seq_control_gen
  import seq_ctrl_pkg::*;
#(
  parameter int N_STATES = 6,
  parameter int BR_FROM  = 2,
  parameter int BR_TO    = 5,
  parameter int LOOP_TO  = 1,
  parameter int CNT_W    = 8
) (
  input  logic                        CLK,
  input  logic                        RESET_N,
  input  logic                        SRST,
  input  logic                        EN,
  input  logic                        CLR,
  input  logic                        MODE,
  input  logic                        START,
  output logic [N_STATES-1:0]         STATE,
  output logic [$clog2(N_STATES)-1:0] STATE_IDX,
  output logic                        DONE,
  output logic [CNT_W-1:0]            LOOP_CNT,
  output logic                        ERR
);

  localparam int IDX_W = $clog2(N_STATES);
  localparam logic [IDX_W-1:0] IDLE_I    = IDX_W'(IDLE_IDX);
  localparam logic [IDX_W-1:0] BR_FROM_I = IDX_W'(BR_FROM);
  localparam logic [IDX_W-1:0] BR_TO_I   = IDX_W'(BR_TO);
  localparam logic [IDX_W-1:0] LOOP_TO_I = IDX_W'(LOOP_TO);
  localparam logic [IDX_W-1:0] LAST_I    = IDX_W'(N_STATES - 1);
  localparam logic [N_STATES-1:0] IDLE_OH = N_STATES'(1) << IDLE_IDX;

  if (N_STATES < 3 || N_STATES > MAX_STATES ||
      BR_FROM < 1 || BR_FROM >= N_STATES - 1 ||
      BR_TO <= BR_FROM + 1 || BR_TO > N_STATES - 1 ||
      LOOP_TO < 1 || LOOP_TO > N_STATES - 1 || CNT_W < 1) begin : g_param_err
    $fatal(1, "seq_control_gen: illegal parameter combination");
  end

  logic [N_STATES-1:0] state_q, state_d;
  logic [CNT_W-1:0]    cnt_q, cnt_d;
  logic                done_q, done_d;
  logic                err_q, err_d;
  logic                legal;
  logic [IDX_W-1:0]    nxt_idx;

  seq_onehot_chk #(.N_STATES(N_STATES)) u_chk (
    .state (state_q),
    .legal (legal)
  );

  assign STATE     = state_q;
  assign STATE_IDX = IDX_W'(onehot_enc(MAX_STATES'(state_q)));
  assign DONE      = done_q;
  assign LOOP_CNT  = cnt_q;
  assign ERR       = err_q;

  // Next state: illegal recovery beats soft reset beats hold beats advance.
  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    err_d   = err_q;
    done_d  = 1'b0;
    nxt_idx = STATE_IDX;
    if (!legal) begin
      state_d = IDLE_OH;
      err_d   = 1'b1;
    end else if (SRST) begin
      state_d = IDLE_OH;
      cnt_d   = '0;
      err_d   = 1'b0;
    end else if (EN) begin
      if (STATE_IDX == IDLE_I) begin
        nxt_idx = (!MODE || START) ? IDX_W'(1) : IDLE_I;
      end else if (STATE_IDX == BR_FROM_I) begin
        nxt_idx = CLR ? BR_TO_I : BR_FROM_I + IDX_W'(1);
      end else if (STATE_IDX == LAST_I) begin
        nxt_idx = MODE ? IDLE_I : LOOP_TO_I;
        done_d  = 1'b1;
        cnt_d   = cnt_q + CNT_W'(1);
      end else begin
        nxt_idx = STATE_IDX + IDX_W'(1);
      end
      state_d          = '0;
      state_d[nxt_idx] = 1'b1;
    end
  end

  // State, counter and flag registers with immediate async reset.
  always_ff @(posedge CLK or negedge RESET_N) begin
    if (!RESET_N) begin
      state_q <= IDLE_OH;
      cnt_q   <= '0;
      done_q  <= 1'b0;
      err_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      done_q  <= done_d;
      err_q   <= err_d;
    end
  end

endmodule

// File: tb/tb_seq_control_gen.sv
// Directed bench for seq_control_gen; a second instance with CNT_W=2
// shares the stimulus to exercise counter wrap.
module tb_seq_control_gen;

  logic       CLK = 1'b0;
  logic       RESET_N, SRST, EN, CLR, MODE, START;
  logic [5:0] STATE, STATE2;
  logic [2:0] STATE_IDX, STATE_IDX2;
  logic       DONE, DONE2, ERR, ERR2;
  logic [7:0] LOOP_CNT;
  logic [1:0] LOOP_CNT2;

  int checks   = 0;
  int failures = 0;

  always #5 CLK = ~CLK;

  seq_control_gen dut (
    .CLK(CLK), .RESET_N(RESET_N), .SRST(SRST), .EN(EN), .CLR(CLR),
    .MODE(MODE), .START(START), .STATE(STATE), .STATE_IDX(STATE_IDX),
    .DONE(DONE), .LOOP_CNT(LOOP_CNT), .ERR(ERR)
  );

  seq_control_gen #(.CNT_W(2)) dut2 (
    .CLK(CLK), .RESET_N(RESET_N), .SRST(SRST), .EN(EN), .CLR(CLR),
    .MODE(MODE), .START(START), .STATE(STATE2), .STATE_IDX(STATE_IDX2),
    .DONE(DONE2), .LOOP_CNT(LOOP_CNT2), .ERR(ERR2)
  );

  // One clock edge; inputs are driven and outputs sampled on the falling edge.
  task automatic tick();
    @(posedge CLK);
    @(negedge CLK);
  endtask

  task automatic test_reset();
    RESET_N = 1'b0; SRST = 1'b0; EN = 1'b0; CLR = 1'b0; MODE = 1'b0; START = 1'b0;
    tick(); tick();
    checks++; if (STATE !== 6'b000001) begin failures++; $display("FAIL reset_state got=%b exp=000001", STATE); end
    checks++; if (STATE_IDX !== 3'd0) begin failures++; $display("FAIL reset_idx got=%0d exp=0", STATE_IDX); end
    checks++; if (DONE !== 1'b0 || ERR !== 1'b0) begin failures++; $display("FAIL reset_flags done=%b err=%b exp=0/0", DONE, ERR); end
    checks++; if (LOOP_CNT !== 8'd0) begin failures++; $display("FAIL reset_cnt got=%0d exp=0", LOOP_CNT); end
    RESET_N = 1'b1;
    tick();
    checks++; if (STATE !== 6'b000001) begin failures++; $display("FAIL hold_after_release got=%b exp=000001", STATE); end
  endtask

  task automatic test_free_run();
    int exp_idx [8] = '{1, 2, 3, 4, 5, 1, 2, 3};
    EN = 1'b1; MODE = 1'b0; CLR = 1'b0;
    for (int i = 0; i < 8; i++) begin
      tick();
      checks++; if (STATE !== (6'b1 << exp_idx[i])) begin failures++; $display("FAIL free_run_state step=%0d got=%b exp_idx=%0d", i, STATE, exp_idx[i]); end
      checks++; if (STATE_IDX !== 3'(exp_idx[i])) begin failures++; $display("FAIL free_run_idx step=%0d got=%0d exp=%0d", i, STATE_IDX, exp_idx[i]); end
      checks++; if (DONE !== (i == 5)) begin failures++; $display("FAIL free_run_done step=%0d got=%b exp=%b", i, DONE, (i == 5)); end
      checks++; if (LOOP_CNT !== ((i >= 5) ? 8'd1 : 8'd0)) begin failures++; $display("FAIL free_run_cnt step=%0d got=%0d", i, LOOP_CNT); end
    end
  endtask

  task automatic test_async_reset();
    #2 RESET_N = 1'b0;
    #1;
    checks++; if (STATE !== 6'b000001) begin failures++; $display("FAIL async_state got=%b exp=000001", STATE); end
    checks++; if (LOOP_CNT !== 8'd0 || DONE !== 1'b0 || ERR !== 1'b0) begin failures++; $display("FAIL async_regs cnt=%0d done=%b err=%b exp=0/0/0", LOOP_CNT, DONE, ERR); end
    EN = 1'b0;
    @(negedge CLK);
    RESET_N = 1'b1;
    tick();
    checks++; if (STATE !== 6'b000001) begin failures++; $display("FAIL async_release got=%b exp=000001", STATE); end
  endtask

  task automatic test_branch();
    int clr_v [9] = '{1, 0, 1, 0, 0, 0, 1, 1, 1};
    int exp_i [9] = '{1, 2, 5, 1, 2, 3, 4, 5, 1};
    int exp_d [9] = '{0, 0, 0, 1, 0, 0, 0, 0, 1};
    EN = 1'b1; MODE = 1'b0;
    for (int i = 0; i < 9; i++) begin
      CLR = clr_v[i][0];
      tick();
      checks++; if (STATE !== (6'b1 << exp_i[i])) begin failures++; $display("FAIL branch_state step=%0d got=%b exp_idx=%0d", i, STATE, exp_i[i]); end
      checks++; if (DONE !== exp_d[i][0]) begin failures++; $display("FAIL branch_done step=%0d got=%b exp=%0d", i, DONE, exp_d[i]); end
    end
    CLR = 1'b0;
    checks++; if (LOOP_CNT !== 8'd2) begin failures++; $display("FAIL branch_cnt got=%0d exp=2", LOOP_CNT); end
  endtask

  task automatic test_hold();
    tick(); tick();
    checks++; if (STATE !== 6'b001000) begin failures++; $display("FAIL hold_setup got=%b exp=001000", STATE); end
    EN = 1'b0;
    for (int i = 0; i < 4; i++) begin
      tick();
      checks++; if (STATE !== 6'b001000 || DONE !== 1'b0) begin failures++; $display("FAIL hold_state cyc=%0d got=%b done=%b exp=001000/0", i, STATE, DONE); end
    end
    checks++; if (LOOP_CNT !== 8'd2) begin failures++; $display("FAIL hold_cnt got=%0d exp=2", LOOP_CNT); end
    SRST = 1'b1;
    tick();
    SRST = 1'b0;
    checks++; if (STATE !== 6'b000001 || LOOP_CNT !== 8'd0) begin failures++; $display("FAIL srst_no_en state=%b cnt=%0d exp=000001/0", STATE, LOOP_CNT); end
  endtask

  task automatic test_single_shot();
    int exp_i [5] = '{2, 3, 4, 5, 0};
    EN = 1'b1; MODE = 1'b1; START = 1'b0;
    for (int i = 0; i < 10; i++) begin
      tick();
      checks++; if (STATE !== 6'b000001) begin failures++; $display("FAIL ss_idle cyc=%0d got=%b exp=000001", i, STATE); end
    end
    START = 1'b1;
    tick();
    START = 1'b0;
    checks++; if (STATE !== 6'b000010) begin failures++; $display("FAIL ss_start got=%b exp=000010", STATE); end
    for (int i = 0; i < 5; i++) begin
      tick();
      checks++; if (STATE !== (6'b1 << exp_i[i])) begin failures++; $display("FAIL ss_seq step=%0d got=%b exp_idx=%0d", i, STATE, exp_i[i]); end
      checks++; if (DONE !== (i == 4)) begin failures++; $display("FAIL ss_done step=%0d got=%b exp=%b", i, DONE, (i == 4)); end
    end
    checks++; if (LOOP_CNT !== 8'd1) begin failures++; $display("FAIL ss_cnt got=%0d exp=1", LOOP_CNT); end
    for (int i = 0; i < 3; i++) begin
      tick();
      checks++; if (STATE !== 6'b000001 || DONE !== 1'b0) begin failures++; $display("FAIL ss_stay cyc=%0d got=%b done=%b", i, STATE, DONE); end
    end
    // MODE flipped mid-pass only changes the exit decision.
    START = 1'b1;
    tick();
    START = 1'b0;
    tick(); tick();
    MODE = 1'b0;
    tick(); tick();
    checks++; if (STATE !== 6'b100000) begin failures++; $display("FAIL ss_mode_mid got=%b exp=100000", STATE); end
    tick();
    checks++; if (STATE !== 6'b000010 || DONE !== 1'b1 || LOOP_CNT !== 8'd2) begin failures++; $display("FAIL ss_mode_exit state=%b done=%b cnt=%0d exp=000010/1/2", STATE, DONE, LOOP_CNT); end
  endtask

  task automatic test_wrap();
    EN = 1'b1; MODE = 1'b0; SRST = 1'b1;
    tick();
    SRST = 1'b0;
    checks++; if (STATE2 !== 6'b000001 || LOOP_CNT2 !== 2'd0 || LOOP_CNT !== 8'd0) begin failures++; $display("FAIL wrap_srst s2=%b c2=%0d c=%0d", STATE2, LOOP_CNT2, LOOP_CNT); end
    for (int i = 1; i <= 21; i++) begin
      tick();
      if (i == 16) begin
        checks++; if (LOOP_CNT2 !== 2'd3) begin failures++; $display("FAIL wrap_cnt3 got=%0d exp=3", LOOP_CNT2); end
      end
    end
    checks++; if (LOOP_CNT2 !== 2'd0) begin failures++; $display("FAIL wrap_cnt0 got=%0d exp=0", LOOP_CNT2); end
    checks++; if (LOOP_CNT !== 8'd4) begin failures++; $display("FAIL wrap_wide got=%0d exp=4", LOOP_CNT); end
    checks++; if (STATE !== 6'b000010 || DONE !== 1'b1) begin failures++; $display("FAIL wrap_state got=%b done=%b exp=000010/1", STATE, DONE); end
  endtask

  task automatic test_illegal();
    force dut.state_q = 6'b000110;
    #1 release dut.state_q;
    #1;
    checks++; if (STATE !== 6'b000110) begin failures++; $display("FAIL ill_deposit got=%b exp=000110", STATE); end
    tick();
    checks++; if (STATE !== 6'b000001 || ERR !== 1'b1) begin failures++; $display("FAIL ill_recover state=%b err=%b exp=000001/1", STATE, ERR); end
    checks++; if (LOOP_CNT !== 8'd4 || DONE !== 1'b0) begin failures++; $display("FAIL ill_cnt cnt=%0d done=%b exp=4/0", LOOP_CNT, DONE); end
    tick(); tick();
    checks++; if (STATE !== 6'b000100 || ERR !== 1'b1) begin failures++; $display("FAIL ill_sticky state=%b err=%b exp=000100/1", STATE, ERR); end
    // All-zero state with SRST: illegal handling wins, counter kept.
    force dut.state_q = 6'b000000;
    #1 release dut.state_q;
    SRST = 1'b1;
    tick();
    checks++; if (STATE !== 6'b000001 || ERR !== 1'b1 || LOOP_CNT !== 8'd4) begin failures++; $display("FAIL ill_over_srst state=%b err=%b cnt=%0d exp=000001/1/4", STATE, ERR, LOOP_CNT); end
    tick();
    SRST = 1'b0;
    checks++; if (ERR !== 1'b0 || LOOP_CNT !== 8'd0 || STATE !== 6'b000001) begin failures++; $display("FAIL ill_clear err=%b cnt=%0d state=%b exp=0/0/000001", ERR, LOOP_CNT, STATE); end
  endtask

  initial begin
    test_reset();
    test_free_run();
    test_async_reset();
    test_branch();
    test_hold();
    test_single_shot();
    test_wrap();
    test_illegal();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
